shared_mem_arbiter: RTL and testbench
=====================================

SHARED_MEM_ARBITER -- requirements
Module: shared_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 13, word address width into the on-chip memory.
REQ-002 Parameter DATA_W, default 32, data width; BE_W = DATA_W/8 (default 4).
REQ-003 Parameter CNT_W, default 16, width of per-port contention counters.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 mN_address  in  ADDR_W  master N word address (N = 0, 1; all mN_ ports duplicated per master).
REQ-007 mN_byteenable  in  BE_W  master N byte lanes for writes.
REQ-008 mN_read / mN_write  in  1 each  master N request strobes.
REQ-009 mN_lock  in  1  master N requests exclusive ownership for the current and following transfers.
REQ-010 mN_writedata  in  DATA_W  master N write data.
REQ-011 mN_waitrequest  out  1  high means master N's request is not accepted this cycle.
REQ-012 mN_readdata  out  DATA_W  read data returned to master N.
REQ-013 mN_readdatavalid  out  1  single-cycle qualifier for mN_readdata.
REQ-014 mem_address, mem_byteenable, mem_writedata  out  ADDR_W, BE_W, DATA_W  to the memory.
REQ-015 mem_chipselect, mem_write, mem_clken  out  1 each  memory controls.
REQ-016 mem_readdata  in  DATA_W  memory output, valid one clk after the read address is presented.
REQ-017 contend_cnt0 / contend_cnt1  out  CNT_W each  saturating count of stalled cycles per master.

Function
REQ-018 A master requests when mN_read or mN_write is high; if both are high, the write SHALL take effect and the read SHALL be ignored.
REQ-019 At most one request SHALL be granted per cycle; the grant is combinational from the requests, the owner state and the priority pointer.
REQ-020 Granted master: mN_waitrequest = 0 and its address/byteenable/writedata/write pass to the memory with mem_chipselect = 1; every other requester sees waitrequest = 1.
REQ-021 No request granted: mem_chipselect = 0, mem_write = 0; mem_clken SHALL be 1 at all times.
REQ-022 Reads use byteenable all-ones toward the memory; writes pass mN_byteenable unmodified.
REQ-023 Read latency is exactly 1 cycle: in the cycle after a granted read, mN_readdatavalid = 1 for that master only and mN_readdata = mem_readdata.
REQ-024 Back-to-back grants are allowed every cycle, including a write immediately after a read and reads alternating between masters.
REQ-025 Writes generate no response.
REQ-026 Arbitration FSM states: IDLE, OWN0, OWN1.
REQ-027 In IDLE with a single requester, that requester wins; with two requesters, the master selected by the 1-bit priority pointer wins.
REQ-028 After every IDLE-state grant the pointer SHALL move to the other master (round-robin).
REQ-029 IDLE -> OWNn when master n is granted with mn_lock = 1.
REQ-030 In OWNn only master n can be granted; the other master waits indefinitely.
REQ-031 OWNn -> IDLE on the first cycle with mn_lock = 0 and no granted mn transfer; a granted transfer with lock = 0 is served and then also returns to IDLE.
REQ-032 The pointer does not change while in OWNn; on return to IDLE it points to the other master.
REQ-033 contend_cntN increments on each cycle where master N requests and mN_waitrequest = 1, and holds at all-ones.
REQ-034 Inputs are not required to be held stable by the arbiter beyond Avalon rules: a waiting master keeps its request stable until waitrequest is low.

Reset
REQ-035 Asserting reset_n low SHALL immediately force: FSM = IDLE, pointer = 0 (master 0 favoured), pending-read flags cleared, contention counters 0.
REQ-036 During reset: mem_chipselect = 0, mem_write = 0, both waitrequest = 1, both readdatavalid = 0, readdata = 0.
REQ-037 A read granted in the cycle before reset assertion SHALL NOT produce readdatavalid after reset release.

Structure
REQ-038 The shared package SHALL hold the FSM state enum (IDLE, OWN0, OWN1) and the default widths ADDR_W = 13, DATA_W = 32, CNT_W = 16.
REQ-039 One sub-module, sat_counter (CNT_W-wide, increment enable, saturating), SHALL be instantiated twice; the rest stays flat.

Verification
REQ-040 Both masters read addr 0x0010 and 0x1FFF in the same cycle after reset -> m0 is granted first, m1 one cycle later; each readdatavalid fires one cycle after its grant; contend_cnt1 = 1.
REQ-041 Both masters issue continuous writes for 8 cycles -> grants alternate 0,1,0,1…; each master completes 4 writes; the memory holds the expected words.
REQ-042 m0 asserts lock and performs 3 writes plus 1 read while m1 requests continuously -> m1 waitrequest stays high throughout; m1 is granted on the cycle after m0 drops lock; m0 read data equals its earlier write.
REQ-043 Write 0xAABBCCDD with byteenable 4'b0101 over 0x00000000, then read back -> 0x00BB00DD.
REQ-044 Issue a read grant, then pull reset_n low in the next cycle -> no readdatavalid pulse; all outputs take their reset values.
REQ-045 Hold m1 stalled under m0 lock for 70000 cycles with CNT_W = 16 -> contend_cnt1 saturates at 0xFFFF.

Source files
------------

// File: rtl/shared_mem_arbiter_pkg.sv
// Shared definitions for the two-master on-chip memory arbiter.
//   DEFAULT_ADDR_W / DEFAULT_DATA_W / DEFAULT_CNT_W : default widths
//   arb_state_t : ownership FSM state (IDLE, OWN0, OWN1)
package shared_mem_arbiter_pkg;

  localparam int DEFAULT_ADDR_W = 13;
  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/shared_mem_arbiter_if.sv
// One master's Avalon-MM style port into the shared memory arbiter.
//   master modport : drives address/byteenable/read/write/lock/writedata,
//                    receives waitrequest/readdata/readdatavalid
//   slave modport  : the arbiter side of the same port
//
// Handshake: a request (read or write high) is accepted on a rising clk
// edge where waitrequest is low; while waitrequest is high the master holds
// its request and all request fields stable. readdatavalid is a one-cycle
// qualifier for readdata, arriving exactly one cycle after an accepted read.
interface shared_mem_arbiter_if
  import shared_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) ();

  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic              lock;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write, lock, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, lock, writedata,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/shared_mem_arbiter_sat_counter.sv
// Saturating up-counter used for per-master contention statistics.
//   clk, reset_n : clock, asynchronous active-low reset (clears to 0)
//   inc          : add one this cycle unless already all-ones
//   count        : current value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Two-master arbiter in front of a single-port on-chip memory with
// one-cycle read latency. Round-robin in IDLE, exclusive ownership while
// the granted master holds lock.
//   clk, reset_n      : clock, asynchronous active-low reset
//   m0, m1            : master ports (slave modport)
//   mem_*             : memory address/byteenable/writedata/controls
//   mem_readdata      : memory output, valid one cycle after the address
//   contend_cnt0/1    : saturating count of stalled request cycles
//   dbg_state         : current ownership FSM state
module shared_mem_arbiter
  import shared_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  shared_mem_arbiter_if.slave   m0,
  shared_mem_arbiter_if.slave   m1,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata,
  output logic [CNT_W-1:0]      contend_cnt0,
  output logic [CNT_W-1:0]      contend_cnt1,
  output arb_state_t            dbg_state
);

  arb_state_t state_q, state_d;
  logic       ptr_q, ptr_d;          // 0: master 0 favoured on a tie
  logic       rd_pend0_q, rd_pend1_q;
  logic       req0, req1;
  logic       gnt0, gnt1;

  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;

  // Grant and next-state. Grants are gated by reset_n so that nothing
  // reaches the memory while reset is held, even with requests present.
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = state_q;
    ptr_d   = ptr_q;
    if (reset_n) begin
      case (state_q)
        IDLE: begin
          if (req0 && (!req1 || !ptr_q)) begin
            gnt0 = 1'b1;
          end else if (req1) begin
            gnt1 = 1'b1;
          end
          if (gnt0) begin
            ptr_d = 1'b1;
            if (m0.lock) state_d = OWN0;
          end
          if (gnt1) begin
            ptr_d = 1'b0;
            if (m1.lock) state_d = OWN1;
          end
        end
        OWN0: begin
          gnt0 = req0;
          // A transfer with lock low is still served; either way ownership
          // ends at this edge and the other master is favoured next.
          if (!m0.lock) begin
            state_d = IDLE;
            ptr_d   = 1'b1;
          end
        end
        OWN1: begin
          gnt1 = req1;
          if (!m1.lock) begin
            state_d = IDLE;
            ptr_d   = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      rd_pend0_q <= 1'b0;
      rd_pend1_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      // A granted request with write low is a read; write wins when both.
      rd_pend0_q <= gnt0 & ~m0.write;
      rd_pend1_q <= gnt1 & ~m1.write;
    end
  end

  // Memory side: master 1 fields when it holds the grant, else master 0.
  always_comb begin
    mem_address    = m0.address;
    mem_writedata  = m0.writedata;
    mem_byteenable = m0.write ? m0.byteenable : '1;
    if (gnt1) begin
      mem_address    = m1.address;
      mem_writedata  = m1.writedata;
      mem_byteenable = m1.write ? m1.byteenable : '1;
    end
  end

  assign mem_chipselect = gnt0 | gnt1;
  assign mem_write      = (gnt0 & m0.write) | (gnt1 & m1.write);
  assign mem_clken      = 1'b1;

  assign m0.waitrequest   = ~gnt0;
  assign m1.waitrequest   = ~gnt1;
  assign m0.readdatavalid = rd_pend0_q;
  assign m1.readdatavalid = rd_pend1_q;
  assign m0.readdata      = rd_pend0_q ? mem_readdata : '0;
  assign m1.readdata      = rd_pend1_q ? mem_readdata : '0;

  assign dbg_state = state_q;

  sat_counter #(.W(CNT_W)) u_cnt0 (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (req0 & ~gnt0),
    .count   (contend_cnt0)
  );

  sat_counter #(.W(CNT_W)) u_cnt1 (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (req1 & ~gnt1),
    .count   (contend_cnt1)
  );

endmodule

// File: tb/tb_shared_mem_arbiter.sv
module tb_shared_mem_arbiter;
  import shared_mem_arbiter_pkg::*;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  localparam int BE_W   = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  shared_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
  shared_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();

  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_chipselect;
  logic              mem_write;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata = '0;
  logic [CNT_W-1:0]  contend_cnt0;
  logic [CNT_W-1:0]  contend_cnt1;
  arb_state_t        dbg_state;

  int total = 0;
  int bad   = 0;

  shared_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .m0             (m0_if),
    .m1             (m1_if),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_writedata  (mem_writedata),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .contend_cnt0   (contend_cnt0),
    .contend_cnt1   (contend_cnt1),
    .dbg_state      (dbg_state)
  );

  // memory model: byte-lane writes, one-cycle registered read
  logic [DATA_W-1:0] mem_model [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] merged;
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      merged = mem_model[mem_address];
      for (int b = 0; b < BE_W; b++)
        if (mem_byteenable[b]) merged[b*8 +: 8] = mem_writedata[b*8 +: 8];
      if (mem_write) mem_model[mem_address] <= merged;
      mem_readdata <= mem_model[mem_address];
    end
  end

  // driver tasks
  task automatic idle_inputs();
    m0_if.address = '0; m0_if.byteenable = '0; m0_if.read = 1'b0;
    m0_if.write = 1'b0; m0_if.lock = 1'b0; m0_if.writedata = '0;
    m1_if.address = '0; m1_if.byteenable = '0; m1_if.read = 1'b0;
    m1_if.write = 1'b0; m1_if.lock = 1'b0; m1_if.writedata = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    m0_if.read = 1'b1; m0_if.address = 13'h0010;
    m1_if.write = 1'b1; m1_if.address = 13'h0020; m1_if.byteenable = 4'hF;
    repeat (2) @(negedge clk);
    #1;
    total++; if (m0_if.waitrequest !== 1'b1) begin bad++; $display("FAIL rst_m0_wait: got %0b want 1", m0_if.waitrequest); end
    total++; if (m1_if.waitrequest !== 1'b1) begin bad++; $display("FAIL rst_m1_wait: got %0b want 1", m1_if.waitrequest); end
    total++; if (mem_chipselect !== 1'b0 || mem_write !== 1'b0) begin bad++; $display("FAIL rst_mem_ctl: got cs=%0b wr=%0b want 0 0", mem_chipselect, mem_write); end
    total++; if (m0_if.readdatavalid !== 1'b0 || m1_if.readdatavalid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b %0b want 0 0", m0_if.readdatavalid, m1_if.readdatavalid); end
    total++; if (m0_if.readdata !== 32'h0 || m1_if.readdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h %h want 0 0", m0_if.readdata, m1_if.readdata); end
    total++; if (contend_cnt0 !== 16'h0 || contend_cnt1 !== 16'h0) begin bad++; $display("FAIL rst_cnt: got %h %h want 0 0", contend_cnt0, contend_cnt1); end
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL rst_state: got %0d want %0d", dbg_state, IDLE); end
    total++; if (mem_clken !== 1'b1) begin bad++; $display("FAIL rst_clken: got %0b want 1", mem_clken); end
    idle_inputs();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_same_cycle_reads();
    apply_reset();
    mem_model[13'h0010] = 32'h1111_0010;
    mem_model[13'h1FFF] = 32'h2222_1FFF;
    @(negedge clk);
    m0_if.read = 1'b1; m0_if.address = 13'h0010;
    m1_if.read = 1'b1; m1_if.address = 13'h1FFF;
    #1;
    total++; if (m0_if.waitrequest !== 1'b0 || m1_if.waitrequest !== 1'b1) begin bad++; $display("FAIL rd_first_grant: got w0=%0b w1=%0b want 0 1", m0_if.waitrequest, m1_if.waitrequest); end
    total++; if (mem_address !== 13'h0010 || mem_byteenable !== 4'hF || mem_chipselect !== 1'b1) begin bad++; $display("FAIL rd_first_mem: got a=%h be=%h cs=%0b want 0010 f 1", mem_address, mem_byteenable, mem_chipselect); end
    @(negedge clk);
    m0_if.read = 1'b0;
    #1;
    total++; if (m0_if.readdatavalid !== 1'b1 || m0_if.readdata !== 32'h1111_0010) begin bad++; $display("FAIL rd_m0_data: got v=%0b d=%h want 1 11110010", m0_if.readdatavalid, m0_if.readdata); end
    total++; if (m1_if.waitrequest !== 1'b0 || mem_address !== 13'h1FFF) begin bad++; $display("FAIL rd_second_grant: got w1=%0b a=%h want 0 1fff", m1_if.waitrequest, mem_address); end
    total++; if (m1_if.readdatavalid !== 1'b0) begin bad++; $display("FAIL rd_m1_early: got %0b want 0", m1_if.readdatavalid); end
    @(negedge clk);
    m1_if.read = 1'b0;
    #1;
    total++; if (m1_if.readdatavalid !== 1'b1 || m1_if.readdata !== 32'h2222_1FFF) begin bad++; $display("FAIL rd_m1_data: got v=%0b d=%h want 1 22221fff", m1_if.readdatavalid, m1_if.readdata); end
    total++; if (m0_if.readdatavalid !== 1'b0) begin bad++; $display("FAIL rd_m0_single: got %0b want 0", m0_if.readdatavalid); end
    total++; if (contend_cnt1 !== 16'd1 || contend_cnt0 !== 16'd0) begin bad++; $display("FAIL rd_cnt: got c0=%0d c1=%0d want 0 1", contend_cnt0, contend_cnt1); end
    @(negedge clk);
    #1;
    total++; if (m1_if.readdatavalid !== 1'b0) begin bad++; $display("FAIL rd_m1_single: got %0b want 0", m1_if.readdatavalid); end
  endtask

  task automatic test_alternating_writes();
    int i0 = 0;
    int i1 = 0;
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      m0_if.write = (i0 < 4); m0_if.byteenable = 4'hF;
      m0_if.address = 13'(13'h100 + i0); m0_if.writedata = 32'(32'hA000_0000 + i0);
      m1_if.write = (i1 < 4); m1_if.byteenable = 4'hF;
      m1_if.address = 13'(13'h200 + i1); m1_if.writedata = 32'(32'hB000_0000 + i1);
      #1;
      total++;
      if (m0_if.waitrequest !== ((c % 2) != 0) || m1_if.waitrequest !== ((c % 2) == 0)) begin
        bad++; $display("FAIL wr_alt_c%0d: got w0=%0b w1=%0b want %0b %0b", c, m0_if.waitrequest, m1_if.waitrequest, (c % 2) != 0, (c % 2) == 0);
      end
      if (!m0_if.waitrequest) i0++;
      if (!m1_if.waitrequest) i1++;
    end
    @(negedge clk);
    idle_inputs();
    #1;
    total++; if (i0 != 4 || i1 != 4) begin bad++; $display("FAIL wr_alt_done: got %0d %0d want 4 4", i0, i1); end
    for (int j = 0; j < 4; j++) begin
      total++; if (mem_model[13'(13'h100 + j)] !== 32'(32'hA000_0000 + j)) begin bad++; $display("FAIL wr_alt_mem0_%0d: got %h want %h", j, mem_model[13'(13'h100 + j)], 32'(32'hA000_0000 + j)); end
      total++; if (mem_model[13'(13'h200 + j)] !== 32'(32'hB000_0000 + j)) begin bad++; $display("FAIL wr_alt_mem1_%0d: got %h want %h", j, mem_model[13'(13'h200 + j)], 32'(32'hB000_0000 + j)); end
    end
    total++; if (contend_cnt0 !== 16'd3 || contend_cnt1 !== 16'd4) begin bad++; $display("FAIL wr_alt_cnt: got %0d %0d want 3 4", contend_cnt0, contend_cnt1); end
  endtask

  task automatic test_lock();
    logic [ADDR_W-1:0] addr_v [4];
    logic [DATA_W-1:0] data_v [4];
    addr_v[0] = 13'h400; addr_v[1] = 13'h401; addr_v[2] = 13'h402; addr_v[3] = 13'h400;
    data_v[0] = 32'h1234_5678; data_v[1] = 32'h0000_0401; data_v[2] = 32'h0000_0402; data_v[3] = '0;
    apply_reset();
    m1_if.write = 1'b1; m1_if.address = 13'h300; m1_if.writedata = 32'hC0C0_C0C0; m1_if.byteenable = 4'hF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      m0_if.lock = 1'b1; m0_if.address = addr_v[c]; m0_if.writedata = data_v[c];
      m0_if.byteenable = 4'hF; m0_if.write = (c < 3); m0_if.read = (c == 3);
      #1;
      total++; if (m0_if.waitrequest !== 1'b0 || m1_if.waitrequest !== 1'b1) begin bad++; $display("FAIL lock_grant_c%0d: got w0=%0b w1=%0b want 0 1", c, m0_if.waitrequest, m1_if.waitrequest); end
      if (c > 0) begin
        total++; if (dbg_state !== OWN0) begin bad++; $display("FAIL lock_state_c%0d: got %0d want %0d", c, dbg_state, OWN0); end
      end
    end
    @(negedge clk);
    m0_if.read = 1'b0; m0_if.write = 1'b0; m0_if.lock = 1'b0;
    #1;
    total++; if (m1_if.waitrequest !== 1'b1) begin bad++; $display("FAIL lock_release_wait: got %0b want 1", m1_if.waitrequest); end
    total++; if (m0_if.readdatavalid !== 1'b1 || m0_if.readdata !== 32'h1234_5678) begin bad++; $display("FAIL lock_rdata: got v=%0b d=%h want 1 12345678", m0_if.readdatavalid, m0_if.readdata); end
    @(negedge clk);
    #1;
    total++; if (dbg_state !== IDLE || m1_if.waitrequest !== 1'b0) begin bad++; $display("FAIL lock_m1_grant: got st=%0d w1=%0b want %0d 0", dbg_state, m1_if.waitrequest, IDLE); end
    total++; if (contend_cnt1 !== 16'd5) begin bad++; $display("FAIL lock_cnt1: got %0d want 5", contend_cnt1); end
    @(negedge clk);
    idle_inputs();
    #1;
    total++; if (mem_model[13'h300] !== 32'hC0C0_C0C0 || mem_model[13'h402] !== 32'h0000_0402) begin bad++; $display("FAIL lock_mem: got %h %h want c0c0c0c0 00000402", mem_model[13'h300], mem_model[13'h402]); end
  endtask

  task automatic test_byteenable();
    apply_reset();
    @(negedge clk);
    m0_if.write = 1'b1; m0_if.address = 13'h050; m0_if.writedata = 32'h0; m0_if.byteenable = 4'hF;
    #1;
    total++; if (m0_if.waitrequest !== 1'b0) begin bad++; $display("FAIL be_clear_grant: got %0b want 0", m0_if.waitrequest); end
    @(negedge clk);
    m0_if.writedata = 32'hAABB_CCDD; m0_if.byteenable = 4'b0101;
    #1;
    total++; if (mem_byteenable !== 4'b0101 || mem_writedata !== 32'hAABB_CCDD || mem_write !== 1'b1) begin bad++; $display("FAIL be_write_bus: got be=%b d=%h wr=%0b want 0101 aabbccdd 1", mem_byteenable, mem_writedata, mem_write); end
    @(negedge clk);
    m0_if.write = 1'b0; m0_if.read = 1'b1;
    #1;
    total++; if (mem_byteenable !== 4'hF || mem_write !== 1'b0) begin bad++; $display("FAIL be_read_bus: got be=%b wr=%0b want 1111 0", mem_byteenable, mem_write); end
    @(negedge clk);
    m0_if.read = 1'b0;
    #1;
    total++; if (m0_if.readdatavalid !== 1'b1 || m0_if.readdata !== 32'h00BB_00DD) begin bad++; $display("FAIL be_readback: got v=%0b d=%h want 1 00bb00dd", m0_if.readdatavalid, m0_if.readdata); end
    @(negedge clk);
    m0_if.read = 1'b1; m0_if.write = 1'b1; m0_if.address = 13'h051;
    m0_if.writedata = 32'h5A5A_5A5A; m0_if.byteenable = 4'hF;
    #1;
    total++; if (mem_write !== 1'b1) begin bad++; $display("FAIL rw_write_wins: got %0b want 1", mem_write); end
    @(negedge clk);
    idle_inputs();
    #1;
    total++; if (m0_if.readdatavalid !== 1'b0 || mem_model[13'h051] !== 32'h5A5A_5A5A) begin bad++; $display("FAIL rw_no_resp: got v=%0b m=%h want 0 5a5a5a5a", m0_if.readdatavalid, mem_model[13'h051]); end
  endtask

  task automatic test_reset_kill();
    apply_reset();
    @(negedge clk);
    m1_if.read = 1'b1; m1_if.address = 13'h0010;
    #1;
    total++; if (m1_if.waitrequest !== 1'b0) begin bad++; $display("FAIL kill_grant: got %0b want 0", m1_if.waitrequest); end
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    total++; if (m1_if.readdatavalid !== 1'b0 || m1_if.readdata !== 32'h0) begin bad++; $display("FAIL kill_valid: got v=%0b d=%h want 0 0", m1_if.readdatavalid, m1_if.readdata); end
    total++; if (m1_if.waitrequest !== 1'b1 || mem_chipselect !== 1'b0 || dbg_state !== IDLE) begin bad++; $display("FAIL kill_outputs: got w1=%0b cs=%0b st=%0d want 1 0 0", m1_if.waitrequest, mem_chipselect, dbg_state); end
    idle_inputs();
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      total++; if (m1_if.readdatavalid !== 1'b0 || m0_if.readdatavalid !== 1'b0) begin bad++; $display("FAIL kill_after_c%0d: got %0b %0b want 0 0", c, m0_if.readdatavalid, m1_if.readdatavalid); end
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    @(negedge clk);
    m0_if.read = 1'b1; m0_if.lock = 1'b1; m0_if.address = 13'h0;
    m1_if.read = 1'b1; m1_if.address = 13'h0010;
    #1;
    total++; if (m0_if.waitrequest !== 1'b0 || m1_if.waitrequest !== 1'b1) begin bad++; $display("FAIL sat_lock_grant: got %0b %0b want 0 1", m0_if.waitrequest, m1_if.waitrequest); end
    @(negedge clk);
    m0_if.read = 1'b0;
    repeat (999) @(negedge clk);
    #1;
    total++; if (contend_cnt1 !== 16'd1000) begin bad++; $display("FAIL sat_cnt_1000: got %0d want 1000", contend_cnt1); end
    repeat (69000) @(negedge clk);
    #1;
    total++; if (contend_cnt1 !== 16'hFFFF || contend_cnt0 !== 16'h0) begin bad++; $display("FAIL sat_cnt_max: got c1=%h c0=%h want ffff 0000", contend_cnt1, contend_cnt0); end
    total++; if (m1_if.waitrequest !== 1'b1 || dbg_state !== OWN0) begin bad++; $display("FAIL sat_still_locked: got w1=%0b st=%0d want 1 %0d", m1_if.waitrequest, dbg_state, OWN0); end
    m0_if.lock = 1'b0;
    @(negedge clk);
    #1;
    total++; if (m1_if.waitrequest !== 1'b0 || contend_cnt1 !== 16'hFFFF) begin bad++; $display("FAIL sat_release: got w1=%0b c1=%h want 0 ffff", m1_if.waitrequest, contend_cnt1); end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    for (int a = 0; a < (1 << ADDR_W); a++) mem_model[a] = '0;
    idle_inputs();
    test_reset();
    test_same_cycle_reads();
    test_alternating_writes();
    test_lock();
    test_byteenable();
    test_reset_kill();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
